// File: rtl/regfile_param_if.sv
// Bus bundle for the parametrised register file: two read ports, one write
// port and the handshaked dump stream towards the debug/trace monitor.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              dump_req;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;
  logic              dump_busy;

  // Decode/writeback/trace side drives addresses, write data and dump control.
  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dump_req, dump_ready,
    input  rd_data_a, rd_data_b, dump_valid, dump_idx, dump_data, dump_done, dump_busy
  );

  // Register file side.
  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dump_req, dump_ready,
    output rd_data_a, rd_data_b, dump_valid, dump_idx, dump_data, dump_done, dump_busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with optional hard-zero entry 0,
// optional write->read bypass and a handshaked sequential dump port.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             CLK,
  input  logic             MasterReset,
  regfile_param_if.slave   bus
);

  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} dumpState_t;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wrLegal;
  logic [DATA_W-1:0] rdDataA;
  logic [DATA_W-1:0] rdDataB;
  dumpState_t        state;
  dumpState_t        nextState;
  logic [ADDR_W-1:0] dumpIdx;
  logic [DATA_W-1:0] dumpData;
  logic [ADDR_W-1:0] dumpNextIdx;
  logic [DATA_W-1:0] dumpNextVal;
  logic              dumpStart;
  logic              dumpAdvance;

  // A write lands only in range and never on the hard-zero entry.
  always_comb begin
    wrLegal = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_EXT)
              && !(ZERO_REG && bus.wr_addr == '0);
  end

  // Storage update; every entry clears on reset.
  // NOTE: the array sits in the reset branch on purpose: software relies on
  // every register reading 0 after reset, so it cannot be left to a RAM macro.
  always_ff @(posedge CLK or posedge MasterReset) begin
    if (MasterReset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrLegal) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read port A: stored value, masked for out-of-range/zero entry, then bypass.
  // NOTE: the default on the first line keeps this block free of inferred
  // latches whatever combination of the following ifs is taken.
  always_comb begin
    rdDataA = '0;
    if (({1'b0, bus.rd_addr_a} < DEPTH_EXT) && !(ZERO_REG && bus.rd_addr_a == '0))
      rdDataA = regs[bus.rd_addr_a];
    if (BYPASS && wrLegal && bus.wr_addr == bus.rd_addr_a)
      rdDataA = bus.wr_data;
  end

  // Read port B: same rules as port A.
  always_comb begin
    rdDataB = '0;
    if (({1'b0, bus.rd_addr_b} < DEPTH_EXT) && !(ZERO_REG && bus.rd_addr_b == '0))
      rdDataB = regs[bus.rd_addr_b];
    if (BYPASS && wrLegal && bus.wr_addr == bus.rd_addr_b)
      rdDataB = bus.wr_data;
  end

  assign bus.rd_data_a = rdDataA;
  assign bus.rd_data_b = rdDataB;

  // Dump FSM state register.
  // NOTE: state-holding processes use <= so every flop samples the values
  // from before the edge, independent of process evaluation order.
  always_ff @(posedge CLK or posedge MasterReset) begin
    if (MasterReset) state <= IDLE;
    else             state <= nextState;
  end

  // Dump FSM next state and beat-load controls.
  always_comb begin
    nextState   = state;
    dumpStart   = 1'b0;
    dumpAdvance = 1'b0;
    unique case (state)
      IDLE: if (bus.dump_req) begin
        nextState = DUMP;
        dumpStart = 1'b1;
      end
      DUMP: if (bus.dump_ready) begin
        if (dumpIdx == LAST_IDX) nextState = DONE;
        else                     dumpAdvance = 1'b1;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Value of the next beat as it will be after this edge, including a
  // coincident write so the beat never carries stale data.
  always_comb begin
    dumpNextIdx = (state == IDLE) ? '0 : dumpIdx + 1'b1;
    dumpNextVal = regs[dumpNextIdx];
    if (ZERO_REG && dumpNextIdx == '0) dumpNextVal = '0;
    if (wrLegal && bus.wr_addr == dumpNextIdx) dumpNextVal = bus.wr_data;
  end

  // Beat register: loaded on start or accept, otherwise held stable.
  always_ff @(posedge CLK or posedge MasterReset) begin
    if (MasterReset) begin
      dumpIdx  <= '0;
      dumpData <= '0;
    end else if (dumpStart || dumpAdvance) begin
      dumpIdx  <= dumpNextIdx;
      dumpData <= dumpNextVal;
    end
  end

  assign bus.dump_valid = (state == DUMP);
  assign bus.dump_done  = (state == DONE);
  assign bus.dump_busy  = (state != IDLE);
  assign bus.dump_idx   = dumpIdx;
  assign bus.dump_data  = dumpData;

endmodule
